// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//
// Ping-pong sweep controller for a WIDTH-bit up/down counter. After an
// accepted START it loads the lower bound into the counter, counts up to the
// upper bound, counts back down to the lower bound, and repeats for CYCLES
// round trips (CYCLES = 0 keeps sweeping until STOP). The counter executes the
// command (en, s, d) on cycles where tick is high; the controller inspects the
// counter value q one cycle later (tick_d), after the counter has updated.
//
// Optional build macro:
//   COUNTER_SEQUENCER_DWELL_EN - hold the counter at each endpoint for DWELL
//                                tick pulses before reversing direction. No
//                                dwell is inserted after the final trip.
//
// Parameters:
//   CYCLES - round trips per run, 0 = continuous until STOP
//   WIDTH  - counter data width
//   DWELL  - tick pulses spent at each endpoint (dwell build only, >= 1)
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   tick   in   one-cycle pulse from the clock divider
//   start  in   single-cycle pulse, begin a run (ignored while busy)
//   stop   in   single-cycle pulse, abort a run (wins over start)
//   lo     in   lower sweep bound, latched on an accepted start
//   hi     in   upper sweep bound, latched on an accepted start
//   q      in   counter value feedback
//   en     out  counter enable
//   s      out  counter mode: 00 hold, 01 load d, 10 up, 11 down
//   d      out  counter load value
//   busy   out  run in progress
//   done   out  one-cycle pulse on normal completion
//   err    out  sticky, set when a start is rejected because lo >= hi
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module counter_sequencer #(
    parameter int CYCLES = 2,
    parameter int WIDTH  = 4,
    parameter int DWELL  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] q,
    output logic             en,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Trip counter only needs to reach CYCLES; a continuous run lets a
    // one-bit counter wrap harmlessly because completion is never checked.
    localparam int TRIP_W = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
    localparam logic [TRIP_W-1:0] TRIP_LAST = TRIP_W'(CYCLES);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    // A dwell of zero ticks would leave the dwell states unreachable-to-exit.
    generate
        if (DWELL < 1) begin : g_bad_dwell
            $error("counter_sequencer: DWELL must be at least 1");
        end
        if (CYCLES < 0) begin : g_bad_cycles
            $error("counter_sequencer: CYCLES must not be negative");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UP,
        ST_DOWN
`ifdef COUNTER_SEQUENCER_DWELL_EN
        ,
        ST_DWELL_HI,
        ST_DWELL_LO
`endif
    } state_t;

`ifdef COUNTER_SEQUENCER_DWELL_EN
    localparam int DWELL_W = (DWELL < 2) ? 1 : $clog2(DWELL);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
`endif

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;
    logic              tick_d;
    logic [WIDTH-1:0]  lo_r;
    logic [WIDTH-1:0]  hi_r;
    logic [WIDTH-1:0]  lo_nxt;
    logic [WIDTH-1:0]  hi_nxt;
    logic [TRIP_W-1:0] trip_cnt;
    logic [TRIP_W-1:0] trip_nxt;
    logic [TRIP_W-1:0] trip_inc;

    // Next values of the registered outputs
    logic              en_nxt;
    logic [1:0]        s_nxt;
    logic [WIDTH-1:0]  d_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              err_nxt;

    // Endpoint detection, valid only on the cycle after a tick
    logic              hit_lo;
    logic              hit_hi;
    logic              final_trip;

`ifdef COUNTER_SEQUENCER_DWELL_EN
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_nxt;
`endif

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tick_d   <= 1'b0;
            lo_r     <= '0;
            hi_r     <= '0;
            trip_cnt <= '0;
            en       <= 1'b0;
            s        <= MODE_HOLD;
            d        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef COUNTER_SEQUENCER_DWELL_EN
            dwell_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            tick_d   <= tick;
            lo_r     <= lo_nxt;
            hi_r     <= hi_nxt;
            trip_cnt <= trip_nxt;
            en       <= en_nxt;
            s        <= s_nxt;
            d        <= d_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
`ifdef COUNTER_SEQUENCER_DWELL_EN
            dwell_cnt <= dwell_nxt;
`endif
        end
    end

    assign hit_lo     = tick_d && (q == lo_r);
    assign hit_hi     = tick_d && (q == hi_r);
    assign trip_inc   = trip_cnt + TRIP_W'(1);
    assign final_trip = (CYCLES != 0) && (trip_inc == TRIP_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        lo_nxt    = lo_r;
        hi_nxt    = hi_r;
        trip_nxt  = trip_cnt;
        done_nxt  = 1'b0;
        err_nxt   = err;
`ifdef COUNTER_SEQUENCER_DWELL_EN
        dwell_nxt = dwell_cnt;
`endif

        case (state)
            ST_IDLE: begin
                // A simultaneous stop cancels the start entirely, including
                // the bounds check, so the pair leaves err untouched.
                if (start && !stop) begin
                    if (lo < hi) begin
                        lo_nxt    = lo;
                        hi_nxt    = hi;
                        trip_nxt  = '0;
                        err_nxt   = 1'b0;
                        state_nxt = ST_LOAD;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                // Keep issuing the load until the counter reports lo_r; a
                // tick that hit while the command was still hold is retried.
                if (hit_lo) begin
                    state_nxt = ST_UP;
                end
            end

            ST_UP: begin
                // Ticks are at least two cycles apart, so hi_r is seen here
                // before the counter is asked to step past it.
                if (hit_hi) begin
`ifdef COUNTER_SEQUENCER_DWELL_EN
                    state_nxt = ST_DWELL_HI;
                    dwell_nxt = '0;
`else
                    state_nxt = ST_DOWN;
`endif
                end
            end

            ST_DOWN: begin
                if (hit_lo) begin
                    trip_nxt = trip_inc;
                    if (final_trip) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
`ifdef COUNTER_SEQUENCER_DWELL_EN
                        state_nxt = ST_DWELL_LO;
                        dwell_nxt = '0;
`else
                        state_nxt = ST_UP;
`endif
                    end
                end
            end

`ifdef COUNTER_SEQUENCER_DWELL_EN
            ST_DWELL_HI: begin
                // The counter holds on each of these ticks; the last one
                // hands over to the down sweep.
                if (tick) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        state_nxt = ST_DOWN;
                    end else begin
                        dwell_nxt = dwell_cnt + DWELL_W'(1);
                    end
                end
            end

            ST_DWELL_LO: begin
                if (tick) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        state_nxt = ST_UP;
                    end else begin
                        dwell_nxt = dwell_cnt + DWELL_W'(1);
                    end
                end
            end
`endif

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abort from any active state; the counter is simply left where it is.
        if (stop && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs line up
    // with the state they describe.
    // -------------------------------------------------------------------------
    always_comb begin
        en_nxt   = 1'b0;
        s_nxt    = MODE_HOLD;
        busy_nxt = (state_nxt != ST_IDLE);
        d_nxt    = (state_nxt == ST_LOAD) ? lo_nxt : d;

        case (state_nxt)
            ST_LOAD: begin
                en_nxt = 1'b1;
                s_nxt  = MODE_LOAD;
            end
            ST_UP: begin
                en_nxt = 1'b1;
                s_nxt  = MODE_UP;
            end
            ST_DOWN: begin
                en_nxt = 1'b1;
                s_nxt  = MODE_DOWN;
            end
            default: begin
                en_nxt = 1'b0;
                s_nxt  = MODE_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
//
// Two sequencers share the clock and divider tick: dut_a runs two round trips
// per run, dut_b runs continuously until stopped. Each drives a behavioural
// up/down counter. A monitor logs the counter value and command after every
// tick executed while a run was active; the expected log is generated from the
// sweep rules (lo, lo+1 .. hi, hi-1 .. lo, repeated, with optional dwell
// repeats at the endpoints).
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam int WIDTH = 4;
    localparam int DWELL = 3;
`ifdef COUNTER_SEQUENCER_DWELL_EN
    localparam int DW = DWELL;
`else
    localparam int DW = 0;
`endif

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic tick = 1'b0;

    logic             start_a, stop_a, en_a, busy_a, done_a, err_a;
    logic [WIDTH-1:0] lo_a, hi_a, q_a, d_a;
    logic [1:0]       s_a;
    logic             start_b, stop_b, en_b, busy_b, done_b, err_b;
    logic [WIDTH-1:0] lo_b, hi_b, q_b, d_b;
    logic [1:0]       s_b;

    int n_cmp = 0;
    int n_bad = 0;

    counter_sequencer #(.CYCLES(2), .WIDTH(WIDTH), .DWELL(DWELL)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .start(start_a), .stop(stop_a),
        .lo(lo_a), .hi(hi_a), .q(q_a), .en(en_a), .s(s_a), .d(d_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    counter_sequencer #(.CYCLES(0), .WIDTH(WIDTH), .DWELL(DWELL)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .start(start_b), .stop(stop_b),
        .lo(lo_b), .hi(hi_b), .q(q_b), .en(en_b), .s(s_b), .d(d_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // Divider: one tick every fourth clock.
    int div = 0;
    always @(negedge clk) begin
        tick = (div == 3);
        div  = (div + 1) % 4;
    end

    // Behavioural 4-bit up/down counters.
    always @(posedge clk) begin
        if (rst) q_a <= '0;
        else if (tick && en_a) begin
            case (s_a)
                2'b01:   q_a <= d_a;
                2'b10:   q_a <= q_a + 4'd1;
                2'b11:   q_a <= q_a - 4'd1;
                default: q_a <= q_a;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst) q_b <= '0;
        else if (tick && en_b) begin
            case (s_b)
                2'b01:   q_b <= d_b;
                2'b10:   q_b <= q_b + 4'd1;
                2'b11:   q_b <= q_b - 4'd1;
                default: q_b <= q_b;
            endcase
        end
    end

    // Monitor: what happened at the last edge.
    logic       lt;
    logic       lb_a, lb_b;
    logic [1:0] ls_a, ls_b;
    always @(posedge clk) begin
        lt   <= tick;
        lb_a <= busy_a;
        lb_b <= busy_b;
        ls_a <= s_a;
        ls_b <= s_b;
    end

    logic [WIDTH-1:0] qlog_a[$];
    logic [1:0]       slog_a[$];
    logic [WIDTH-1:0] qlog_b[$];
    logic [1:0]       slog_b[$];
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always @(negedge clk) begin
        if (lt === 1'b1 && lb_a === 1'b1) begin
            qlog_a.push_back(q_a);
            slog_a.push_back(ls_a);
        end
        if (lt === 1'b1 && lb_b === 1'b1) begin
            qlog_b.push_back(q_b);
            slog_b.push_back(ls_b);
        end
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    // Reference sweep: value and command seen after each active tick.
    logic [WIDTH-1:0] exp_q[$];
    logic [1:0]       exp_s[$];

    task automatic build_model(input int lo, input int hi, input int trips);
        exp_q.delete();
        exp_s.delete();
        exp_q.push_back(4'(lo)); exp_s.push_back(2'b01);
        for (int t = 1; t <= trips; t++) begin
            for (int v = lo + 1; v <= hi; v++) begin
                exp_q.push_back(4'(v)); exp_s.push_back(2'b10);
            end
            for (int k = 0; k < DW; k++) begin
                exp_q.push_back(4'(hi)); exp_s.push_back(2'b00);
            end
            for (int v = hi - 1; v >= lo; v--) begin
                exp_q.push_back(4'(v)); exp_s.push_back(2'b11);
            end
            if (t < trips) begin
                for (int k = 0; k < DW; k++) begin
                    exp_q.push_back(4'(lo)); exp_s.push_back(2'b00);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b1; stop_a = 1'b0; lo_a = 4'd3; hi_a = 4'd6;
        start_b = 1'b1; stop_b = 1'b0; lo_b = 4'd3; hi_b = 4'd6;
        step();
        step();
        n_cmp++;
        if ({en_a, s_a, d_a, busy_a, done_a, err_a} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_a: got en=%b s=%b d=%0d busy=%b done=%b err=%b, want all 0",
                     en_a, s_a, d_a, busy_a, done_a, err_a);
        end
        n_cmp++;
        if ({en_b, s_b, d_b, busy_b, done_b, err_b} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_b: got en=%b s=%b d=%0d busy=%b done=%b err=%b, want all 0",
                     en_b, s_b, d_b, busy_b, done_b, err_b);
        end
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        step();
        n_cmp++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got busy_a=%b busy_b=%b, want 0 0", busy_a, busy_b);
        end
    endtask

    // One full CYCLES=2 run on dut_a. With poke set, lo/hi are scrambled and
    // start is pulsed mid-run; both must be ignored.
    task automatic run_sweep(input int lo, input int hi, input bit poke, input string name);
        bit seen;
        int first_bad;
        int got_q;
        step();
        lo_a = 4'(lo); hi_a = 4'(hi);
        repeat ($urandom_range(0, 3)) step();
        qlog_a.delete(); slog_a.delete(); done_cnt_a = 0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        build_model(lo, hi, 2);
        // A start taken on a tick edge holds once; if the counter already
        // sat at lo, the sweep legitimately begins without a load.
        if (lt === 1'b1 && q_a == 4'(lo)) begin
            void'(exp_q.pop_front());
            void'(exp_s.pop_front());
        end
        n_cmp++;
        if (busy_a !== 1'b1 || err_a !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_start: got busy=%b err=%b, want busy=1 err=0", name, busy_a, err_a);
        end
        seen = 1'b0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            if (poke && k == 6) begin
                lo_a = 4'($urandom); hi_a = 4'($urandom); start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            step();
            if (done_a === 1'b1) seen = 1'b1;
        end
        start_a = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_done_timeout: got no done within 4000 cycles, want one", name);
        end else begin
            n_cmp++;
            if (busy_a !== 1'b0 || en_a !== 1'b0 || s_a !== 2'b00) begin
                n_bad++;
                $display("FAIL %s_done_cycle: got busy=%b en=%b s=%b, want 0 0 00",
                         name, busy_a, en_a, s_a);
            end
            step();
            n_cmp++;
            if (done_a !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_done_width: got done=%b one cycle later, want 0", name, done_a);
            end
        end
        repeat (8) step();
        n_cmp++;
        if (done_cnt_a != 1 || err_a !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done_count: got %0d pulses err=%b, want 1 pulse err=0",
                     name, done_cnt_a, err_a);
        end
        first_bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (first_bad < 0 && (i >= qlog_a.size() || qlog_a[i] !== exp_q[i]
                                  || slog_a[i] !== exp_s[i])) first_bad = i;
        end
        if (first_bad < 0 && qlog_a.size() != exp_q.size()) first_bad = exp_q.size();
        n_cmp++;
        if (first_bad >= 0) begin
            n_bad++;
            got_q = (first_bad < qlog_a.size()) ? int'(qlog_a[first_bad]) : -1;
            $display("FAIL %s_seq: got %0d steps, q=%0d at step %0d; want %0d steps, q=%0d",
                     name, qlog_a.size(), got_q, first_bad, exp_q.size(),
                     (first_bad < exp_q.size()) ? int'(exp_q[first_bad]) : -1);
        end
    endtask

    task automatic test_nominal();
        run_sweep(2, 5, 1'b0, "nominal");
    endtask

    task automatic test_bad_bounds();
        int l;
        int h;
        step();
        lo_a = 4'd7; hi_a = 4'd7; start_a = 1'b1;
        step();
        start_a = 1'b0;
        n_cmp++;
        if (err_a !== 1'b1 || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_equal: got err=%b busy=%b, want err=1 busy=0", err_a, busy_a);
        end
        repeat (3) step();
        n_cmp++;
        if (err_a !== 1'b1 || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_sticky: got err=%b busy=%b, want err=1 busy=0", err_a, busy_a);
        end
        for (int i = 0; i < 3; i++) begin
            l = $urandom_range(1, 15);
            h = $urandom_range(0, l - 1);
            lo_a = 4'(l); hi_a = 4'(h); start_a = 1'b1;
            step();
            start_a = 1'b0;
            step();
            n_cmp++;
            if (err_a !== 1'b1 || busy_a !== 1'b0) begin
                n_bad++;
                $display("FAIL bad_reversed lo=%0d hi=%0d: got err=%b busy=%b, want 1 0",
                         l, h, err_a, busy_a);
            end
        end
        run_sweep(1, 3, 1'b0, "recover");
    endtask

    task automatic test_abort();
        bit found;
        step();
        lo_a = 4'd2; hi_a = 4'd5; start_a = 1'b1;
        step();
        start_a = 1'b0;
        done_cnt_a = 0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            step();
            if (lt === 1'b1 && s_a === 2'b11 && q_a === 4'd4) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL abort_reach: got no down step to 4 within 400 cycles, want one");
        end
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b0 || en_a !== 1'b0 || s_a !== 2'b00 || done_a !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b en=%b s=%b done=%b, want 0 0 00 0",
                     busy_a, en_a, s_a, done_a);
        end
        repeat (12) step();
        n_cmp++;
        if (q_a !== 4'd4 || done_cnt_a != 0) begin
            n_bad++;
            $display("FAIL abort_frozen: got q=%0d done pulses=%0d, want q=4 pulses=0",
                     q_a, done_cnt_a);
        end
        // start+stop together from idle, good and bad bounds: nothing happens.
        start_a = 1'b1; stop_a = 1'b1;
        step();
        start_a = 1'b0; stop_a = 1'b0;
        step();
        n_cmp++;
        if (busy_a !== 1'b0 || err_a !== 1'b0) begin
            n_bad++;
            $display("FAIL startstop_good: got busy=%b err=%b, want 0 0", busy_a, err_a);
        end
        lo_a = 4'd9; hi_a = 4'd3; start_a = 1'b1; stop_a = 1'b1;
        step();
        start_a = 1'b0; stop_a = 1'b0;
        step();
        n_cmp++;
        if (busy_a !== 1'b0 || err_a !== 1'b0) begin
            n_bad++;
            $display("FAIL startstop_bad: got busy=%b err=%b, want 0 0", busy_a, err_a);
        end
    endtask

    task automatic test_continuous();
        int n;
        int first_bad;
        bit reached;
        step();
        lo_b = 4'd0; hi_b = 4'd15;
        qlog_b.delete(); slog_b.delete(); done_cnt_b = 0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        build_model(0, 15, 3);
        if (lt === 1'b1 && q_b == 4'd0) begin
            void'(exp_q.pop_front());
            void'(exp_s.pop_front());
        end
        n = exp_q.size();
        reached = 1'b0;
        for (int k = 0; k < 3000 && !reached; k++) begin
            step();
            if (qlog_b.size() >= n) reached = 1'b1;
        end
        stop_b = 1'b1;
        step();
        stop_b = 1'b0;
        n_cmp++;
        if (!reached) begin
            n_bad++;
            $display("FAIL cont_timeout: got %0d steps in 3000 cycles, want %0d", qlog_b.size(), n);
        end
        n_cmp++;
        if (busy_b !== 1'b0 || en_b !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_stop: got busy=%b en=%b after stop, want 0 0", busy_b, en_b);
        end
        repeat (10) step();
        n_cmp++;
        if (done_cnt_b != 0 || q_b !== 4'd0) begin
            n_bad++;
            $display("FAIL cont_end: got done pulses=%0d q=%0d, want 0 pulses q=0", done_cnt_b, q_b);
        end
        first_bad = -1;
        for (int i = 0; i < n; i++) begin
            if (first_bad < 0 && (i >= qlog_b.size() || qlog_b[i] !== exp_q[i]
                                  || slog_b[i] !== exp_s[i])) first_bad = i;
        end
        if (first_bad < 0 && qlog_b.size() != n) first_bad = n;
        n_cmp++;
        if (first_bad >= 0) begin
            n_bad++;
            $display("FAIL cont_seq: got %0d steps, q=%0d at step %0d; want %0d steps, q=%0d",
                     qlog_b.size(),
                     (first_bad < qlog_b.size()) ? int'(qlog_b[first_bad]) : -1,
                     first_bad, n, (first_bad < n) ? int'(exp_q[first_bad]) : -1);
        end
    endtask

    task automatic test_dwell();
        run_sweep(0, 2, 1'b0, "dwell");
    endtask

    task automatic test_random();
        int l;
        int h;
        for (int i = 0; i < 4; i++) begin
            l = $urandom_range(0, 13);
            h = $urandom_range(l + 1, 15);
            run_sweep(l, h, 1'b1, $sformatf("rand%0d_%0d_%0d", i, l, h));
        end
    endtask

    task automatic test_reset_midrun();
        step();
        lo_a = 4'd2; hi_a = 4'd5; start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (20) step();
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_busy: got busy=%b before reset, want 1", busy_a);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({en_a, s_a, d_a, busy_a, done_a, err_a} !== 10'd0) begin
            n_bad++;
            $display("FAIL midrun_reset: got en=%b s=%b d=%0d busy=%b done=%b err=%b, want all 0",
                     en_a, s_a, d_a, busy_a, done_a, err_a);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by 2 ms, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_nominal();
        test_bad_bounds();
        test_abort();
        test_continuous();
        test_dwell();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
